// File: rtl/matrix_read_sequencer_if.sv
// Read-side bus of the matrix read sequencer:
// RAM read port plus the tagged element stream.
interface matrix_read_sequencer_if #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int CW = 3
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          out_last;

  modport master (
    output rd_en, rd_addr,
    output out_valid, out_data,
    output out_row, out_col, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr,
    input  out_valid, out_data,
    input  out_row, out_col, out_last,
    output rd_data, out_ready
  );
endinterface

// File: rtl/matrix_read_sequencer.sv
// Walks a DIM x DIM matrix in a 1-cycle RAM and
// streams elements tagged with row, col and last.
module matrix_read_sequencer #(
  parameter int DIM       = 3,
  parameter int DW        = 8,
  parameter int TRANSPOSE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  matrix_read_sequencer_if.master bus
);
  localparam int N  = DIM * DIM;
  localparam int AW = $clog2(DIM*DIM-1) + 1;
  localparam int CW = $clog2(DIM) + 1;
  localparam int IW = $clog2(N + 1) + 1;
  localparam logic [CW-1:0] IMAX = CW'(DIM - 1);

  typedef enum logic [1:0] {
    IDLE, READ, DRAIN, DONE
  } state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          last;
  } ent_t;

  state_t        state_q, state_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [IW-1:0] issued_q, issued_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] inf_row_q, inf_row_d;
  logic [CW-1:0] inf_col_q, inf_col_d;
  logic          inf_last_q, inf_last_d;
  ent_t          ent0_q, ent0_d;
  ent_t          ent1_q, ent1_d;
  logic [1:0]    occ_q, occ_d;

  ent_t arr;
  ent_t head;
  logic valid;
  logic pop;
  logic rd_en;
  logic last_issue;

  // Head of stream: buffered entry, else the word
  // arriving from RAM this cycle (no bubble).
  always_comb begin
    arr = '{data: bus.rd_data,
            row:  inf_row_q,
            col:  inf_col_q,
            last: inf_last_q};
    valid = (occ_q != 2'd0) | inflight_q;
    head = '0;
    if (occ_q != 2'd0) begin
      head = ent0_q;
    end else if (inflight_q) begin
      head = arr;
    end
    pop = valid & bus.out_ready;
  end

  // Issue a read only if its data has a slot.
  always_comb begin
    last_issue = (issued_q == IW'(N - 1));
    rd_en = (state_q == READ)
          & (issued_q < IW'(N))
          & (({1'b0, occ_q}
              + {2'b0, inflight_q} < 3'd2)
             | pop);
  end

  // Two-entry FIFO: store arrivals not consumed
  // directly, shift on pop.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    unique case (occ_q)
      2'd0: begin
        if (inflight_q & ~pop) begin
          ent0_d = arr;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (pop) begin
          if (inflight_q) ent0_d = arr;
          else            occ_d  = 2'd0;
        end else if (inflight_q) begin
          ent1_d = arr;
          occ_d  = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          ent0_d = ent1_q;
          if (inflight_q) ent1_d = arr;
          else            occ_d  = 2'd1;
        end
      end
    endcase
  end

  // Scan control and index counters.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    issued_d   = issued_q;
    inflight_d = rd_en;
    inf_row_d  = inf_row_q;
    inf_col_d  = inf_col_q;
    inf_last_d = inf_last_q;
    if (rd_en) begin
      inf_row_d  = row_q;
      inf_col_d  = col_q;
      inf_last_d = last_issue;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = READ;
          row_d    = '0;
          col_d    = '0;
          issued_d = '0;
        end
      end
      READ: begin
        if (rd_en) begin
          issued_d = issued_q + IW'(1);
          if (TRANSPOSE == 0) begin
            if (col_q == IMAX) begin
              col_d = '0;
              row_d = (row_q == IMAX) ? '0
                    : row_q + CW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end else begin
            if (row_q == IMAX) begin
              row_d = '0;
              col_d = (col_q == IMAX) ? '0
                    : col_q + CW'(1);
            end else begin
              row_d = row_q + CW'(1);
            end
          end
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (occ_d == 2'd0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Drive status and bus outputs.
  always_comb begin
    busy = (state_q == READ)
         | (state_q == DRAIN);
    done = (state_q == DONE);
    bus.rd_en   = rd_en;
    bus.rd_addr = AW'(32'(row_q) * DIM
                      + 32'(col_q));
    bus.out_valid = valid;
    bus.out_data  = head.data;
    bus.out_row   = head.row;
    bus.out_col   = head.col;
    bus.out_last  = head.last;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      inf_row_q  <= '0;
      inf_col_q  <= '0;
      inf_last_q <= 1'b0;
      ent0_q     <= '0;
      ent1_q     <= '0;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      inf_row_q  <= inf_row_d;
      inf_col_q  <= inf_col_d;
      inf_last_q <= inf_last_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      occ_q      <= occ_d;
    end
  end
endmodule
